// File: rtl/lr35902_snd_seq_pkg.sv
// Shared constants and types for the sound frame sequencer: step event masks,
// length maxima and the NRx2 envelope register layout.
package lr35902_snd_seq_pkg;

   localparam logic [7:0] LEN_STEPS = 8'b01010101;
   localparam logic [7:0] SWP_STEPS = 8'b01000100;
   localparam logic [7:0] ENV_STEPS = 8'b10000000;

   localparam int LEN_MAX_SQ   = 64;
   localparam int LEN_MAX_WAVE = 256;

   typedef struct packed {
      logic [3:0] vol;
      logic       dir;
      logic [2:0] per;
   } env_cfg_t;

   // A zero period still arms the timer with 8 so a later live period change counts from a full span.
   function automatic logic [3:0] env_period(input logic [2:0] per);
      return (per == 3'd0) ? 4'd8 : {1'b0, per};
   endfunction

endpackage

// File: rtl/lr35902_snd_env.sv
// Volume envelope for one square/noise channel: period timer plus 4-bit volume
// that steps up or down on each timer expiry and saturates at 0/15.
module lr35902_snd_env
   import lr35902_snd_seq_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       tick,
   input  logic       trig,
   input  logic [7:0] cfg,
   output logic [3:0] vol
);

   env_cfg_t   c;
   logic [3:0] vol_q, vol_d;
   logic [3:0] tmr_q, tmr_d;

   assign c   = env_cfg_t'(cfg);
   assign vol = vol_q;

   always_comb begin
      vol_d = vol_q;
      tmr_d = tmr_q;
      if (!en) begin
         vol_d = 4'd0;
         tmr_d = 4'd0;
      end else if (trig) begin
         vol_d = c.vol;
         tmr_d = env_period(c.per);
      end else if (tick && (c.per != 3'd0)) begin
         // A timer already at 0 (never triggered) is treated as expired rather than wrapping.
         if (tmr_q <= 4'd1) begin
            tmr_d = {1'b0, c.per};
            if (c.dir && (vol_q != 4'hF))
               vol_d = vol_q + 4'd1;
            else if (!c.dir && (vol_q != 4'h0))
               vol_d = vol_q - 4'd1;
         end else begin
            tmr_d = tmr_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vol_q <= 4'd0;
         tmr_q <= 4'd0;
      end else begin
         vol_q <= vol_d;
         tmr_q <= tmr_d;
      end
   end

endmodule

// File: rtl/lr35902_snd_seq.sv
// Sound frame sequencer: prescaler to the 512 Hz frame step, length/sweep/envelope
// event scheduling, per-channel length counters and channel-on flags.
module lr35902_snd_seq
   import lr35902_snd_seq_pkg::*;
#(
   parameter int PRESCALE = 8192
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       snd_on,
   input  logic [3:0] trig,
   input  logic [3:0] len_en,
   input  logic [3:0] len_load,
   input  logic [7:0] len_din,
   input  logic [3:0] dac_on,
   input  logic [7:0] env_cfg1,
   input  logic [7:0] env_cfg2,
   input  logic [7:0] env_cfg4,
   output logic [3:0] ch_on,
   output logic [3:0] vol1,
   output logic [3:0] vol2,
   output logic [3:0] vol4,
   output logic       sweep_tick,
   output logic [2:0] step
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pre_q, pre_d;
   logic [2:0]    step_q, step_d;
   logic          swp_q, swp_d;
   logic          frame_tick, len_clk, env_clk;
   logic [3:0]    trig_ok;

   assign frame_tick = snd_on && (pre_q == PW'(PRESCALE - 1));
   assign len_clk    = frame_tick && LEN_STEPS[step_q];
   assign env_clk    = frame_tick && ENV_STEPS[step_q];
   assign trig_ok    = trig & {4{snd_on}};

   assign step       = step_q;
   assign sweep_tick = swp_q;

   always_comb begin
      pre_d  = pre_q;
      step_d = step_q;
      swp_d  = 1'b0;
      if (!snd_on) begin
         pre_d  = '0;
         step_d = 3'd0;
      end else if (frame_tick) begin
         pre_d  = '0;
         step_d = step_q + 3'd1;
         swp_d  = SWP_STEPS[step_q];
      end else begin
         pre_d  = pre_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q  <= '0;
         step_q <= 3'd0;
         swp_q  <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         step_q <= step_d;
         swp_q  <= swp_d;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_len
      localparam int LW  = (i == 2) ? 9 : 7;
      localparam int MAX = (i == 2) ? LEN_MAX_WAVE : LEN_MAX_SQ;

      logic [LW-1:0] cnt_q, cnt_d, load_val;
      logic          on_q, on_d;

      assign load_val = LW'(9'(MAX) - ((i == 2) ? {1'b0, len_din} : {3'b0, len_din[5:0]}));
      assign ch_on[i] = on_q;

      // Trigger outranks a same-cycle load, which outranks the length clock.
      always_comb begin
         cnt_d = cnt_q;
         on_d  = on_q;
         if (trig_ok[i]) begin
            if (cnt_q == '0)
               cnt_d = LW'(MAX);
            on_d = dac_on[i];
         end else if (len_load[i]) begin
            cnt_d = load_val;
         end else if (len_clk && len_en[i] && (cnt_q != '0)) begin
            cnt_d = cnt_q - LW'(1);
            if (cnt_q == LW'(1))
               on_d = 1'b0;
         end
         if (!snd_on || !dac_on[i])
            on_d = 1'b0;
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt_q <= '0;
            on_q  <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            on_q  <= on_d;
         end
      end
   end

   lr35902_snd_env u_env1 (
      .clk   (clk),
      .reset (reset),
      .en    (snd_on),
      .tick  (env_clk),
      .trig  (trig_ok[0]),
      .cfg   (env_cfg1),
      .vol   (vol1)
   );

   lr35902_snd_env u_env2 (
      .clk   (clk),
      .reset (reset),
      .en    (snd_on),
      .tick  (env_clk),
      .trig  (trig_ok[1]),
      .cfg   (env_cfg2),
      .vol   (vol2)
   );

   lr35902_snd_env u_env4 (
      .clk   (clk),
      .reset (reset),
      .en    (snd_on),
      .tick  (env_clk),
      .trig  (trig_ok[3]),
      .cfg   (env_cfg4),
      .vol   (vol4)
   );

endmodule

// File: tb/tb_lr35902_snd_seq.sv
// Directed bench for the sound frame sequencer with an 8-cycle frame step.
module tb_lr35902_snd_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       snd_on;
   logic [3:0] trig, len_en, len_load, dac_on;
   logic [7:0] len_din, env_cfg1, env_cfg2, env_cfg4;
   logic [3:0] ch_on, vol1, vol2, vol4;
   logic       sweep_tick;
   logic [2:0] step;

   int checks   = 0;
   int failures = 0;

   lr35902_snd_seq #(.PRESCALE(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .snd_on     (snd_on),
      .trig       (trig),
      .len_en     (len_en),
      .len_load   (len_load),
      .len_din    (len_din),
      .dac_on     (dac_on),
      .env_cfg1   (env_cfg1),
      .env_cfg2   (env_cfg2),
      .env_cfg4   (env_cfg4),
      .ch_on      (ch_on),
      .vol1       (vol1),
      .vol2       (vol2),
      .vol4       (vol4),
      .sweep_tick (sweep_tick),
      .step       (step)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Holds snd_on low for one edge so the sequencer restarts from step 0, count 0.
   task automatic restart();
      snd_on = 1'b0;
      run(1);
      snd_on = 1'b1;
   endtask

   initial begin
      int bad_step, sw_cnt, sw_bad;
      reset = 1'b0; snd_on = 1'b1;
      trig = '0; len_en = '0; len_load = '0; dac_on = '0; len_din = '0;
      env_cfg1 = '0; env_cfg2 = '0; env_cfg4 = '0;
      run(3);
      check_eq("rst_step", step, 0);
      check_eq("rst_ch_on", ch_on, 0);
      check_eq("rst_vols", {vol1, vol2, vol4}, 0);
      check_eq("rst_sweep", sweep_tick, 0);

      reset = 1'b1;
      run(7);
      check_eq("first_tick_before", step, 0);
      run(1);
      check_eq("first_tick_after", step, 1);
      bad_step = 0; sw_cnt = 0; sw_bad = 0;
      for (int k = 9; k <= 72; k++) begin
         run(1);
         if (step != 3'((k / 8) % 8)) bad_step++;
         if (sweep_tick) begin
            sw_cnt++;
            if (!(step == 3'd3 || step == 3'd7)) sw_bad++;
         end
      end
      check_eq("step_walk", bad_step, 0);
      check_eq("sweep_count", sw_cnt, 2);
      check_eq("sweep_phase", sw_bad, 0);

      restart();
      dac_on = 4'b0001; len_en = 4'b0001; len_din = 8'd62; len_load = 4'b0001;
      run(1);
      len_load = '0; trig = 4'b0001;
      run(1);
      trig = '0;
      check_eq("ch1_on", ch_on, 4'b0001);
      run(21);
      check_eq("ch1_before_2nd_len", ch_on[0], 1);
      run(1);
      check_eq("ch1_off_2nd_len", ch_on[0], 0);

      trig = 4'b0001;
      run(1);
      trig = '0;
      check_eq("ch1_retrig", ch_on[0], 1);
      dac_on = '0;
      run(1);
      check_eq("ch1_dac_off", ch_on[0], 0);

      restart();
      dac_on = 4'b0100; len_en = '0; len_din = 8'd0; len_load = 4'b0100;
      run(1);
      len_load = '0; trig = 4'b0100;
      run(1);
      trig = '0;
      check_eq("ch3_on", ch_on, 4'b0100);
      run(7998);
      check_eq("ch3_1000_frames", ch_on[2], 1);
      len_en = 4'b0100;
      run(4087);
      check_eq("ch3_before_256", ch_on[2], 1);
      run(1);
      check_eq("ch3_off_256", ch_on[2], 0);

      restart();
      dac_on = 4'b0010; len_en = '0; env_cfg2 = 8'hF1; trig = 4'b0010;
      run(1);
      trig = '0;
      check_eq("env_dn_init", vol2, 15);
      run(62);
      check_eq("env_dn_hold", vol2, 15);
      run(1);
      check_eq("env_dn_1", vol2, 14);
      run(64 * 14);
      check_eq("env_dn_zero", vol2, 0);
      run(128);
      check_eq("env_dn_floor", vol2, 0);
      env_cfg2 = 8'h0A; trig = 4'b0010;
      run(1);
      trig = '0;
      check_eq("env_up_init", vol2, 0);
      run(63);
      check_eq("env_up_half", vol2, 0);
      run(64);
      check_eq("env_up_1", vol2, 1);
      run(64 * 27);
      check_eq("env_up_14", vol2, 14);
      run(64);
      check_eq("env_up_15", vol2, 15);
      run(256);
      check_eq("env_up_ceiling", vol2, 15);

      restart();
      dac_on = 4'b1000; len_en = 4'b1000;
      run(7);
      trig = 4'b1000;
      run(1);
      trig = '0;
      check_eq("ch4_trig_len_clk", ch_on, 4'b1000);
      run(1023);
      check_eq("ch4_before_64", ch_on[3], 1);
      run(1);
      check_eq("ch4_off_64", ch_on[3], 0);
      dac_on = '0; trig = 4'b1000;
      run(1);
      trig = '0;
      check_eq("ch4_trig_dac_off", ch_on[3], 0);

      restart();
      dac_on = 4'b0001; len_en = '0; env_cfg1 = 8'hF0; trig = 4'b0001;
      run(1);
      trig = '0;
      run(20);
      check_eq("pre_arst_step", step, 2);
      check_eq("pre_arst_state", {ch_on, vol1}, {4'b0001, 4'hF});
      #3 reset = 1'b0;
      #1;
      check_eq("arst_step", step, 0);
      check_eq("arst_ch_vol", {ch_on, vol1}, 0);
      run(1);
      reset = 1'b1;

      restart();
      dac_on = 4'b0001; len_en = 4'b0001; env_cfg1 = 8'hF0; len_din = 8'd60; len_load = 4'b0001;
      run(1);
      len_load = '0; trig = 4'b0001;
      run(1);
      trig = '0;
      check_eq("keep_on", {ch_on, vol1}, {4'b0001, 4'hF});
      run(6);
      snd_on = 1'b0;
      run(1);
      check_eq("snd_off_clear", {ch_on, vol1}, 0);
      snd_on = 1'b1; trig = 4'b0001;
      run(1);
      trig = '0;
      check_eq("keep_retrig", ch_on[0], 1);
      run(38);
      check_eq("keep_before_3", ch_on[0], 1);
      run(1);
      check_eq("keep_off_3", ch_on[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
